// File: rtl/crack_pkg.sv
// ---------------------------------------------------------------------------
// crack_pkg
// Shared definitions for the crack dispatch block.
//   KEY_W        key width seen by the crack cores
//   KEY_NONE     result key reported when no core finds a key
//   PT_LEN_ADDR  plaintext address holding the length byte
//   state_t      dispatch FSM states
// ---------------------------------------------------------------------------
package crack_pkg;

   localparam int              KEY_W       = 24;
   localparam logic [KEY_W-1:0] KEY_NONE    = 24'hFFFFFF;
   localparam logic [7:0]      PT_LEN_ADDR = 8'h00;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LAUNCH    = 3'd1,
      S_WAIT_BUSY = 3'd2,
      S_SEARCH    = 3'd3,
      S_COPY      = 3'd4,
      S_DONE      = 3'd5
   } state_t;

endpackage

// File: rtl/crack_pt_copier.sv
// ---------------------------------------------------------------------------
// crack_pt_copier
// Copies a length-prefixed plaintext (byte 0 = length L, bytes 1..L) from a
// source memory with one cycle of read latency into a destination memory.
// One read address is issued per cycle; the byte returned for address a is
// written to address a in the following cycle. A copy takes L+2 cycles and
// performs exactly L+1 writes.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   start       one-cycle pulse, begins a copy at address 0
//   rddata      source memory q (valid the cycle after rd_addr)
//   rd_addr     source read address
//   wr_addr     destination write address
//   wr_data     destination write data (0 when not writing)
//   wren        destination write enable
//   done        high during the final write cycle
// ---------------------------------------------------------------------------
module crack_pt_copier
   import crack_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] rddata,
   output logic [7:0] rd_addr,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       wren,
   output logic       done
);

   logic       busy;
   logic [8:0] cnt;       // address being issued this cycle; 9 bits so L=255 can stop at 256
   logic       wr_v;      // a read was issued last cycle, so rddata is live now
   logic [7:0] wr_addr_q;
   logic [7:0] len_q;
   logic [7:0] cur_len;
   logic       issue;

   assign rd_addr = cnt[7:0];
   assign wr_addr = wr_addr_q;

   always_comb begin
      // The length byte is used in the same cycle it returns so that the
      // decision to issue address 1 does not cost an extra cycle.
      cur_len = len_q;
      if (wr_v && (wr_addr_q == PT_LEN_ADDR)) cur_len = rddata;
      issue   = busy && ((cnt == 9'd0) || (cnt <= {1'b0, cur_len}));
      wren    = busy && wr_v;
      done    = wren && !issue;
      wr_data = wren ? rddata : 8'h00;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy      <= 1'b0;
         cnt       <= 9'd0;
         wr_v      <= 1'b0;
         wr_addr_q <= 8'h00;
         len_q     <= 8'h00;
      end else if (start) begin
         busy      <= 1'b1;
         cnt       <= 9'd0;
         wr_v      <= 1'b0;
         wr_addr_q <= 8'h00;
      end else if (busy) begin
         if (done) begin
            busy      <= 1'b0;
            cnt       <= 9'd0;
            wr_v      <= 1'b0;
            wr_addr_q <= 8'h00;
         end else begin
            cnt       <= cnt + 9'd1;
            wr_v      <= issue;
            wr_addr_q <= cnt[7:0];
            if (wr_v && (wr_addr_q == PT_LEN_ADDR)) len_q <= rddata;
         end
      end
   end

endmodule

// File: rtl/crack_dispatch.sv
// ---------------------------------------------------------------------------
// crack_dispatch
// Splits the key space across NUM_CORES crack cores (core i starts at key i
// and steps by NUM_CORES), launches them together, picks the lowest-index core
// reporting a valid key, and copies that core's plaintext into the result pt
// memory.
// Handshake: a start request is accepted on any edge where en=1 and rdy=1;
// en is ignored whenever rdy=0. rdy stays low until the result is final.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   en / rdy             start request / idle
//   key, key_valid       result key (KEY_NONE if none), plaintext copied
//   core_en              one-cycle start pulse to every core
//   core_rdy, core_key, core_key_valid   per-core status (packed, core i low)
//   core_start_key, core_key_inc         constant key-space partition
//   core_pt_addr_copy, core_pt_wren_copy, core_pt_rddata   core pt read path
//   res_addr, res_wrdata, res_wren       result pt memory write port
//   state                FSM state, for observation
// ---------------------------------------------------------------------------
module crack_dispatch
   import crack_pkg::*;
#(
   parameter int NUM_CORES = 2,
   parameter int KEY_W     = crack_pkg::KEY_W
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       en,
   output logic                       rdy,
   output logic [KEY_W-1:0]           key,
   output logic                       key_valid,
   output logic [NUM_CORES-1:0]       core_en,
   input  logic [NUM_CORES-1:0]       core_rdy,
   input  logic [NUM_CORES*KEY_W-1:0] core_key,
   input  logic [NUM_CORES-1:0]       core_key_valid,
   output logic [NUM_CORES*KEY_W-1:0] core_start_key,
   output logic [KEY_W-1:0]           core_key_inc,
   output logic [7:0]                 core_pt_addr_copy,
   output logic                       core_pt_wren_copy,
   input  logic [NUM_CORES*8-1:0]     core_pt_rddata,
   output logic [7:0]                 res_addr,
   output logic [7:0]                 res_wrdata,
   output logic                       res_wren,
   output state_t                     state
);

   localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   state_t           state_nxt;
   logic [NUM_CORES-1:0] win;
   logic             win_any;
   logic [IDX_W-1:0] win_idx;
   logic [KEY_W-1:0] win_key;
   logic [IDX_W-1:0] winner_q;
   logic             found_q;
   logic [7:0]       pt_q;
   logic             copy_start;
   logic             copy_done;

   // Constant key-space partition.
   for (genvar g = 0; g < NUM_CORES; g++) begin : g_start_key
      assign core_start_key[g*KEY_W +: KEY_W] = KEY_W'(g);
   end
   assign core_key_inc      = KEY_W'(NUM_CORES);
   assign core_pt_wren_copy = 1'b0;

   // Lowest index wins when several cores finish in the same cycle.
   always_comb begin
      win     = core_rdy & core_key_valid;
      win_any = |win;
      win_idx = '0;
      win_key = '0;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         if (win[i]) begin
            win_idx = IDX_W'(i);
            win_key = core_key[i*KEY_W +: KEY_W];
         end
      end
   end

   always_comb begin
      pt_q = 8'h00;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (winner_q == IDX_W'(i)) pt_q = core_pt_rddata[i*8 +: 8];
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; core_rdy is not looked at in WAIT_BUSY because the
   // cores are still showing their pre-launch rdy there.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:      if (en) state_nxt = S_LAUNCH;
         S_LAUNCH:    state_nxt = S_WAIT_BUSY;
         S_WAIT_BUSY: state_nxt = S_SEARCH;
         S_SEARCH: begin
            if (win_any)        state_nxt = S_COPY;
            else if (&core_rdy) state_nxt = S_DONE;
         end
         S_COPY:      if (copy_done) state_nxt = S_DONE;
         S_DONE:      state_nxt = S_IDLE;
         default:     state_nxt = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      rdy        = (state == S_IDLE);
      core_en    = (state == S_LAUNCH) ? '1 : '0;
      copy_start = (state == S_SEARCH) && win_any;
   end

   // Result registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         key       <= '0;
         key_valid <= 1'b0;
         found_q   <= 1'b0;
         winner_q  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (en) begin
                  key_valid <= 1'b0;
                  found_q   <= 1'b0;
               end
            end
            S_SEARCH: begin
               if (win_any) begin
                  key      <= win_key;
                  winner_q <= win_idx;
                  found_q  <= 1'b1;
               end else if (&core_rdy) begin
                  key <= KEY_NONE;
               end
            end
            S_DONE:  key_valid <= found_q;
            default: ;
         endcase
      end
   end

   crack_pt_copier u_copier (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (copy_start),
      .rddata  (pt_q),
      .rd_addr (core_pt_addr_copy),
      .wr_addr (res_addr),
      .wr_data (res_wrdata),
      .wren    (res_wren),
      .done    (copy_done)
   );

endmodule

// File: tb/tb_crack_dispatch.sv
module tb_crack_dispatch;
   import crack_pkg::*;

   localparam int NC = 2;
   localparam int KW = 24;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            en;
   logic            rdy;
   logic [KW-1:0]   key;
   logic            key_valid;
   logic [NC-1:0]   core_en;
   logic [NC-1:0]   core_rdy;
   logic [NC*KW-1:0] core_key;
   logic [NC-1:0]   core_key_valid;
   logic [NC*KW-1:0] core_start_key;
   logic [KW-1:0]   core_key_inc;
   logic [7:0]      core_pt_addr_copy;
   logic            core_pt_wren_copy;
   logic [NC*8-1:0] core_pt_rddata;
   logic [7:0]      res_addr;
   logic [7:0]      res_wrdata;
   logic            res_wren;
   state_t          state;

   int checks = 0;
   int errors = 0;
   int launches = 0;

   // clock / reset block
   always #5 clk = ~clk;

   crack_dispatch #(.NUM_CORES(NC), .KEY_W(KW)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .en                (en),
      .rdy               (rdy),
      .key               (key),
      .key_valid         (key_valid),
      .core_en           (core_en),
      .core_rdy          (core_rdy),
      .core_key          (core_key),
      .core_key_valid    (core_key_valid),
      .core_start_key    (core_start_key),
      .core_key_inc      (core_key_inc),
      .core_pt_addr_copy (core_pt_addr_copy),
      .core_pt_wren_copy (core_pt_wren_copy),
      .core_pt_rddata    (core_pt_rddata),
      .res_addr          (res_addr),
      .res_wrdata        (res_wrdata),
      .res_wren          (res_wren),
      .state             (state)
   );

   // per-core plaintext memories, one cycle read latency
   logic [7:0] mem [0:NC-1][0:255];
   logic [7:0] q0, q1;
   always @(posedge clk) begin
      q0 <= mem[0][core_pt_addr_copy];
      q1 <= mem[1][core_pt_addr_copy];
   end
   assign core_pt_rddata = {q1, q0};

   // result-memory write capture and launch-pulse counter
   logic [7:0] wa_q[$];
   logic [7:0] wd_q[$];
   always @(negedge clk) begin
      if (rst_n && res_wren) begin
         wa_q.push_back(res_addr);
         wd_q.push_back(res_wrdata);
      end
      if (rst_n && (core_en != '0)) launches++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_pt(input int c, input int len, input int seed);
      mem[c][0] = 8'(len);
      for (int a = 1; a < 256; a++) mem[c][a] = 8'(a * seed + c + 1);
   endtask

   // drive one complete request; en is also pulsed while busy
   task automatic run_search(input string tag, input logic [1:0] rdy_v,
                             input logic [1:0] kv_v, input logic [47:0] keys);
      bit got;
      wa_q.delete();
      wd_q.delete();
      launches = 0;
      en = 1'b1;
      tick();
      en = 1'b0;
      check({tag, "_launch_en"}, 32'(core_en), 32'h3);
      check({tag, "_launch_rdy"}, 32'(rdy), 32'h0);
      core_rdy       = 2'b00;
      core_key_valid = 2'b00;
      tick();
      en = 1'b1;
      tick();
      en = 1'b0;
      core_rdy       = rdy_v;
      core_key_valid = kv_v;
      core_key       = keys;
      got = 1'b0;
      for (int cyc = 0; cyc < 1000; cyc++) begin
         tick();
         if (rdy) begin
            got = 1'b1;
            break;
         end
      end
      check({tag, "_finished"}, 32'(got), 32'h1);
      check({tag, "_one_launch"}, 32'(launches), 32'h1);
      check({tag, "_idle_state"}, 32'(state), 32'(S_IDLE));
      core_rdy       = 2'b11;
      core_key_valid = 2'b00;
   endtask

   task automatic verify_copy(input string tag, input int c, input int len);
      check({tag, "_nwrites"}, 32'(wa_q.size()), 32'(len + 1));
      for (int a = 0; a <= len; a++) begin
         if (a < wa_q.size()) begin
            check({tag, "_waddr"}, 32'(wa_q[a]), 32'(a));
            check({tag, "_wdata"}, 32'(wd_q[a]), 32'(mem[c][a]));
         end
      end
   endtask

   initial begin
      rst_n          = 1'b0;
      en             = 1'b0;
      core_rdy       = 2'b11;
      core_key_valid = 2'b00;
      core_key       = '0;
      fill_pt(0, 9, 7);
      fill_pt(1, 5, 3);
      tick();
      tick();

      // reset state
      check("rst_rdy", 32'(rdy), 32'h1);
      check("rst_key", 32'(key), 32'h0);
      check("rst_key_valid", 32'(key_valid), 32'h0);
      check("rst_core_en", 32'(core_en), 32'h0);
      check("rst_pt_addr", 32'(core_pt_addr_copy), 32'h0);
      check("rst_res_addr", 32'(res_addr), 32'h0);
      check("rst_res_wrdata", 32'(res_wrdata), 32'h0);
      check("rst_res_wren", 32'(res_wren), 32'h0);
      check("rst_state", 32'(state), 32'(S_IDLE));
      rst_n = 1'b1;
      tick();
      check("start_key_lo", 32'(core_start_key[23:0]), 32'd0);
      check("start_key_hi", 32'(core_start_key[47:24]), 32'd1);
      check("key_inc", 32'(core_key_inc), 32'd2);
      check("pt_wren_copy", 32'(core_pt_wren_copy), 32'h0);

      // core1 finds key 3 while core0 still searching, L=5
      run_search("core1", 2'b10, 2'b10, {24'd3, 24'd0});
      check("core1_key", 32'(key), 32'd3);
      check("core1_key_valid", 32'(key_valid), 32'h1);
      verify_copy("core1", 1, 5);

      // both cores valid together: lowest index wins
      fill_pt(0, 3, 5);
      fill_pt(1, 4, 11);
      run_search("tie", 2'b11, 2'b11, {24'd5, 24'd4});
      check("tie_key", 32'(key), 32'd4);
      check("tie_key_valid", 32'(key_valid), 32'h1);
      verify_copy("tie", 0, 3);

      // exhausted without a key
      run_search("none", 2'b11, 2'b00, {24'd9, 24'd8});
      check("none_key", 32'(key), 32'(KEY_NONE));
      check("none_key_valid", 32'(key_valid), 32'h0);
      check("none_nwrites", 32'(wa_q.size()), 32'd0);

      // zero-length plaintext
      fill_pt(0, 0, 9);
      run_search("len0", 2'b01, 2'b01, {24'd0, 24'h123456});
      check("len0_key", 32'(key), 32'h123456);
      check("len0_key_valid", 32'(key_valid), 32'h1);
      verify_copy("len0", 0, 0);

      // maximum-length plaintext
      fill_pt(1, 255, 13);
      run_search("len255", 2'b10, 2'b10, {24'hABCDEF, 24'd0});
      check("len255_key", 32'(key), 32'hABCDEF);
      check("len255_key_valid", 32'(key_valid), 32'h1);
      verify_copy("len255", 1, 255);
      if (wa_q.size() > 0) check("len255_last_addr", 32'(wa_q[wa_q.size()-1]), 32'd255);

      // reset in the middle of a copy
      wa_q.delete();
      wd_q.delete();
      en = 1'b1;
      tick();
      en = 1'b0;
      core_rdy = 2'b00;
      tick();
      tick();
      core_rdy       = 2'b10;
      core_key_valid = 2'b10;
      core_key       = {24'd7, 24'd0};
      tick();
      tick();
      tick();
      tick();
      check("midcopy_wren", 32'(res_wren), 32'h1);
      check("midcopy_state", 32'(state), 32'(S_COPY));
      rst_n = 1'b0;
      tick();
      check("abort_rdy", 32'(rdy), 32'h1);
      check("abort_wren", 32'(res_wren), 32'h0);
      check("abort_key_valid", 32'(key_valid), 32'h0);
      check("abort_state", 32'(state), 32'(S_IDLE));
      rst_n          = 1'b1;
      core_rdy       = 2'b11;
      core_key_valid = 2'b00;
      tick();

      // restart after abort
      fill_pt(1, 5, 17);
      run_search("restart", 2'b10, 2'b10, {24'd3, 24'd0});
      check("restart_key", 32'(key), 32'd3);
      check("restart_key_valid", 32'(key_valid), 32'h1);
      verify_copy("restart", 1, 5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
